sum_collector: RTL



---
 rtl/sum_collector.sv | 104 ++++++++++
 1 files changed

// File: rtl/sum_collector.sv
// sum_collector: gathers N sums from an upstream adder into one frame result (total, max, carry count).
// Latency: out_valid rises 1 cycle after the Nth sample is accepted; result held until out_ready.
// Backpressure: in_ready drops while a result waits in HOLD; no sample is taken in the handshake cycle.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   sum, in_valid       - incoming sample and its valid strobe
//   in_ready            - combinational: 1 in IDLE/ACC, 0 in HOLD or during reset
//   total, max_sum      - running / final frame sum and largest sample (registered)
//   carry_cnt           - count of samples with their MSB set (registered)
//   out_valid, out_ready- frame result handshake
//   busy                - frame in progress (ACC or HOLD), registered
module sum_collector #(
  parameter int N     = 4,
  parameter int SUM_W = 5,
  parameter int ACC_W = SUM_W + $clog2(N),
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] sum,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] total,
  output logic [SUM_W-1:0] max_sum,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic             accept;

  // Zero-extended operands: ACC_W leaves room for N full-scale samples, so the sum never wraps.
  logic [ACC_W-1:0] sum_ext;
  logic [CNT_W-1:0] msb_ext;

  assign sum_ext = {{(ACC_W-SUM_W){1'b0}}, sum};
  assign msb_ext = {{(CNT_W-1){1'b0}}, sum[SUM_W-1]};

  // Next-state and in_ready. in_ready depends only on state and rst, never on in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = ACC;
      end
      ACC: begin
        in_ready = !rst;
        // count holds samples already taken; N-1 means this accept completes the frame.
        if (in_valid && (count == CNT_W'(N - 1))) state_nxt = HOLD;
      end
      HOLD: begin
        // Handshake cycle: in_ready stays low so the next frame starts one cycle later.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      total     <= '0;
      max_sum   <= '0;
      carry_cnt <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE);
      if (accept) begin
        if (state == IDLE) begin
          // First sample of a frame overwrites whatever the previous frame left behind.
          total     <= sum_ext;
          max_sum   <= sum;
          carry_cnt <= msb_ext;
          count     <= CNT_W'(1);
        end else begin
          total     <= total + sum_ext;
          max_sum   <= (sum > max_sum) ? sum : max_sum;
          carry_cnt <= carry_cnt + msb_ext;
          count     <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule
